// File: rtl/reservation_station_param.sv
// -----------------------------------------------------------------------------
// reservation_station_param
//   Generic Tomasulo reservation station, one instance per functional-unit
//   class. Holds up to DEPTH dispatched instructions, snoops the CDB for
//   pending operands and issues the oldest operand-complete entry to its FU.
//   Entry i owns tag TAG_BASE+i.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   disp_valid/disp_ready    dispatch handshake from the IDU
//   disp_op                  instruction type
//   disp_s{1,2}_rdy/val/tag  source operand: value when rdy, producer tag otherwise
//   disp_tag                 tag allocated to the current dispatch (0 when no fire)
//   cdb_valid/tag/data       common data bus broadcast
//   issue_valid/fu_ready     issue handshake to the FU
//   issue_op/a/b/tag         selected entry (all 0 when issue_valid is low)
//   rs_full                  all entries busy (AR_Status / MR_Status)
//   rs_count                 number of busy entries
// -----------------------------------------------------------------------------
module reservation_station_param #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned OP_W     = 8,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned TAG_BASE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_op,
  input  logic                       disp_s1_rdy,
  input  logic [DATA_W-1:0]          disp_s1_val,
  input  logic [TAG_W-1:0]           disp_s1_tag,
  input  logic                       disp_s2_rdy,
  input  logic [DATA_W-1:0]          disp_s2_val,
  input  logic [TAG_W-1:0]           disp_s2_tag,
  output logic [TAG_W-1:0]           disp_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       issue_valid,
  input  logic                       fu_ready,
  output logic [OP_W-1:0]            issue_op,
  output logic [DATA_W-1:0]          issue_a,
  output logic [DATA_W-1:0]          issue_b,
  output logic [TAG_W-1:0]           issue_tag,
  output logic                       rs_full,
  output logic [$clog2(DEPTH+1)-1:0] rs_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [TAG_W-1:0] BASE_C  = TAG_W'(TAG_BASE);

  // Entry state
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  r_r1;
  logic [DEPTH-1:0]  r_r2;
  logic [OP_W-1:0]   r_op  [DEPTH];
  logic [TAG_W-1:0]  r_q1  [DEPTH];
  logic [TAG_W-1:0]  r_q2  [DEPTH];
  logic [DATA_W-1:0] r_v1  [DEPTH];
  logic [DATA_W-1:0] r_v2  [DEPTH];
  logic [IDX_W-1:0]  r_age [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic              r_full;

  logic [IDX_W-1:0]  w_free_idx;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [IDX_W-1:0]  w_sel_age;
  logic              w_sel_found;
  logic              w_disp_fire;
  logic              w_issue_fire;
  logic              w_fwd1;
  logic              w_fwd2;
  logic [IDX_W-1:0]  w_new_age;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // Lowest-index free slot: scan from the top so the last hit wins.
  always_comb begin
    w_free_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!r_busy[DEPTH-1-k]) w_free_idx = IDX_W'(DEPTH-1-k);
    end
  end

  // Oldest operand-complete entry; ages are unique so no tie-break is needed.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sel_age   = '1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_busy[i] && r_r1[i] && r_r2[i] &&
          (!w_sel_found || (r_age[i] < w_sel_age))) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
        w_sel_age   = r_age[i];
      end
    end
  end

  assign disp_ready   = (r_count < DEPTH_C);
  assign w_disp_fire  = disp_valid & disp_ready;
  assign w_issue_fire = w_sel_found & fu_ready;

  assign disp_tag = w_disp_fire ? (BASE_C + TAG_W'(w_free_idx)) : '0;

  assign issue_valid = w_sel_found;
  assign issue_op    = w_sel_found ? r_op[w_sel_idx] : '0;
  assign issue_a     = w_sel_found ? r_v1[w_sel_idx] : '0;
  assign issue_b     = w_sel_found ? r_v2[w_sel_idx] : '0;
  assign issue_tag   = w_sel_found ? (BASE_C + TAG_W'(w_sel_idx)) : '0;

  assign rs_full  = r_full;
  assign rs_count = r_count;

  // Same-cycle forwarding of a broadcast into a dispatching source.
  assign w_fwd1 = !disp_s1_rdy && cdb_valid && (disp_s1_tag == cdb_tag);
  assign w_fwd2 = !disp_s2_rdy && cdb_valid && (disp_s2_tag == cdb_tag);

  // New entry is youngest after any concurrent issue compacts the ages.
  assign w_new_age = IDX_W'(r_count - CNT_W'(w_issue_fire));

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_disp_fire && !w_issue_fire) w_cnt_nxt = r_count + CNT_W'(1);
    if (!w_disp_fire && w_issue_fire) w_cnt_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= '0;
      r_r1    <= '0;
      r_r2    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_op[i]  <= '0;
        r_q1[i]  <= '0;
        r_q2[i]  <= '0;
        r_v1[i]  <= '0;
        r_v2[i]  <= '0;
        r_age[i] <= '0;
      end
    end else begin
      // CDB snoop and age compaction touch busy entries only, so they never
      // collide with the dispatch write into the free slot below.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_busy[i]) begin
          if (!r_r1[i] && cdb_valid && (r_q1[i] == cdb_tag)) begin
            r_v1[i] <= cdb_data;
            r_r1[i] <= 1'b1;
          end
          if (!r_r2[i] && cdb_valid && (r_q2[i] == cdb_tag)) begin
            r_v2[i] <= cdb_data;
            r_r2[i] <= 1'b1;
          end
          if (w_issue_fire && (r_age[i] > w_sel_age)) begin
            r_age[i] <= r_age[i] - IDX_W'(1);
          end
        end
      end

      if (w_issue_fire) r_busy[w_sel_idx] <= 1'b0;

      if (w_disp_fire) begin
        r_busy[w_free_idx] <= 1'b1;
        r_op[w_free_idx]   <= disp_op;
        r_q1[w_free_idx]   <= disp_s1_tag;
        r_q2[w_free_idx]   <= disp_s2_tag;
        r_r1[w_free_idx]   <= disp_s1_rdy | w_fwd1;
        r_r2[w_free_idx]   <= disp_s2_rdy | w_fwd2;
        r_v1[w_free_idx]   <= w_fwd1 ? cdb_data : disp_s1_val;
        r_v2[w_free_idx]   <= w_fwd2 ? cdb_data : disp_s2_val;
        r_age[w_free_idx]  <= w_new_age;
      end

      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == DEPTH_C);
    end
  end

endmodule
